// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: latches a 128-bit state and transforms COLS_PER_CYCLE
// columns per cycle in place, with valid/ready handshakes on input and output.
module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadCols
         $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        stateQ, stateD;
   logic [1:0]    cntQ, cntD;
   logic [127:0]  workQ, workD;
   logic [127:0]  resultQ, resultD;
   logic [1:0]    colIdx;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   // Multiples 9/B/D/E are built from x2, x4, x8 so only three xtime stages per byte.
   function automatic logic [31:0] invMixColumn(input logic [31:0] col);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mB [4];
      logic [7:0] mD [4];
      logic [7:0] mE [4];
      for (int r = 0; r < 4; r++) begin
         a     = col[31-8*r -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[r] = x8 ^ a;
         mB[r] = x8 ^ x2 ^ a;
         mD[r] = x8 ^ x4 ^ a;
         mE[r] = x8 ^ x4 ^ x2;
      end
      return {mE[0] ^ mB[1] ^ mD[2] ^ m9[3],
              m9[0] ^ mE[1] ^ mB[2] ^ mD[3],
              mD[0] ^ m9[1] ^ mE[2] ^ mB[3],
              mB[0] ^ mD[1] ^ m9[2] ^ mE[3]};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ  <= IDLE;
         cntQ    <= '0;
         workQ   <= '0;
         resultQ <= '0;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         workQ   <= workD;
         resultQ <= resultD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (in_valid)          stateD = CALC;
         CALC:    if (cntQ == CNT_LAST)  stateD = DONE;
         DONE:    if (out_ready)         stateD = IDLE;
         default:                        stateD = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (stateQ == IDLE);
      busy      = (stateQ == CALC) || (stateQ == DONE);
      out_valid = (stateQ == DONE);
   end

   // resultQ is only refreshed on the last CALC edge, so state_out holds across new work.
   always_comb begin
      workD   = workQ;
      cntD    = cntQ;
      resultD = resultQ;
      colIdx  = '0;
      case (stateQ)
         IDLE: begin
            if (in_valid) begin
               workD = state_in;
               cntD  = '0;
            end
         end
         CALC: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
               colIdx = cntQ + 2'(g);
               workD[127 - 32*int'(colIdx) -: 32] = invMixColumn(workQ[127 - 32*int'(colIdx) -: 32]);
            end
            cntD = cntQ + CNT_STEP;
            if (cntQ == CNT_LAST) resultD = workD;
         end
         default: ;
      endcase
   end

   assign state_out = resultQ;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter: one instance per legal COLS_PER_CYCLE,
// fixed vectors, handshake corner cases and a GF(2^8) matrix reference model.
module tb_inv_mix_columns_iter;

   localparam int NDUT = 3;

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   logic         clk = 1'b0;
   logic         rstN;
   logic         inValid  [NDUT];
   logic         inReady  [NDUT];
   logic [127:0] stateIn  [NDUT];
   logic         outValid [NDUT];
   logic         outReady [NDUT];
   logic [127:0] stateOut [NDUT];
   logic         busy     [NDUT];

   int   checkCount = 0;
   int   passCount  = 0;
   vec_t vecs [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
         .clk       (clk),
         .rst_n     (rstN),
         .in_valid  (inValid[g]),
         .in_ready  (inReady[g]),
         .state_in  (stateIn[g]),
         .out_valid (outValid[g]),
         .out_ready (outReady[g]),
         .state_out (stateOut[g]),
         .busy      (busy[g])
      );
   end

   // Reference: schoolbook polynomial product reduced by 0x11B, then a circulant matrix.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] mixState(input logic [127:0] s, input logic [31:0] row0);
      logic [127:0] res;
      logic [7:0]   acc;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gfMul(row0[31 - 8*((j - r + 4) % 4) -: 8], s[127 - 32*c - 8*j -: 8]);
            res[127 - 32*c - 8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] fwdModel(input logic [127:0] s);
      return mixState(s, 32'h02030101);
   endfunction

   function automatic logic [127:0] invModel(input logic [127:0] s);
      return mixState(s, 32'h0E0B0D09);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Offers one state with out_ready held high; cycles counts edges from the accepting one.
   task automatic applyStimulus(input int k, input logic [127:0] data, output int cycles,
                                output logic [127:0] result, output logic timedOut);
      int waitCnt;
      waitCnt = 0;
      while (!inReady[k] && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      stateIn[k]  = data;
      inValid[k]  = 1'b1;
      outReady[k] = 1'b1;
      tick();
      inValid[k]  = 1'b0;
      stateIn[k]  = rand128();
      cycles      = 1;
      while (!outValid[k] && cycles < 50) begin
         tick();
         cycles++;
      end
      result   = stateOut[k];
      timedOut = !outValid[k];
      tick();
   endtask

   task automatic runDut(input int k);
      int           n, cyc, got, idx, acceptCyc [3];
      logic [127:0] res, held, d [3], results [3];
      logic         to, acceptNow, outNow, sawValid;
      string        tag;
      n   = 4 / (1 << k);
      tag = $sformatf("dut%0d", k);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(k, vecs[i].din, cyc, res, to);
         checkOutput($sformatf("%s vec%0d data", tag, i), res, vecs[i].dout);
         checkInt($sformatf("%s vec%0d latency", tag, i), cyc, n + 1);
      end

      // Backpressure with ignored input pulses during DONE
      stateIn[k] = vecs[0].din; inValid[k] = 1'b1; outReady[k] = 1'b0;
      tick();
      inValid[k] = 1'b0;
      cyc = 0;
      while (!outValid[k] && cyc < 20) begin tick(); cyc++; end
      checkBit({tag, " bp reach done"}, outValid[k], 1'b1);
      for (int i = 0; i < 10; i++) begin
         inValid[k] = i[0];
         stateIn[k] = rand128();
         tick();
         checkBit($sformatf("%s bp valid %0d", tag, i), outValid[k], 1'b1);
         checkBit($sformatf("%s bp ready %0d", tag, i), inReady[k], 1'b0);
         checkOutput($sformatf("%s bp data %0d", tag, i), stateOut[k], vecs[0].dout);
      end
      inValid[k] = 1'b0; outReady[k] = 1'b1;
      tick();
      checkBit({tag, " bp release valid"}, outValid[k], 1'b0);
      checkBit({tag, " bp release ready"}, inReady[k], 1'b1);
      checkOutput({tag, " bp hold idle"}, stateOut[k], vecs[0].dout);
      stateIn[k] = '0; inValid[k] = 1'b1;
      tick();
      inValid[k] = 1'b0;
      checkBit({tag, " hold busy"}, busy[k], 1'b1);
      checkOutput({tag, " hold during calc"}, stateOut[k], vecs[0].dout);
      cyc = 0;
      while (!outValid[k] && cyc < 20) begin tick(); cyc++; end
      checkOutput({tag, " zero after hold"}, stateOut[k], '0);
      tick();

      // Reset in the second CALC cycle (the only one when n == 1)
      stateIn[k] = vecs[0].din; inValid[k] = 1'b1; outReady[k] = 1'b1;
      tick();
      inValid[k] = 1'b0;
      if (n > 1) tick();
      checkBit({tag, " mid calc busy"}, busy[k], 1'b1);
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      checkBit({tag, " rst valid"}, outValid[k], 1'b0);
      checkBit({tag, " rst ready"}, inReady[k], 1'b1);
      checkBit({tag, " rst busy"}, busy[k], 1'b0);
      checkOutput({tag, " rst data"}, stateOut[k], '0);
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         sawValid = sawValid | outValid[k];
      end
      checkBit({tag, " no partial result"}, sawValid, 1'b0);
      applyStimulus(k, vecs[0].din, cyc, res, to);
      checkOutput({tag, " post rst data"}, res, vecs[0].dout);
      checkInt({tag, " post rst latency"}, cyc, n + 1);

      // Back-to-back with in_valid held high
      for (int i = 0; i < 3; i++) d[i] = rand128();
      idx = 0; got = 0; cyc = 0;
      stateIn[k] = d[0]; inValid[k] = 1'b1; outReady[k] = 1'b1;
      while (got < 3 && cyc < 100) begin
         acceptNow = inReady[k] && inValid[k];
         outNow    = outValid[k] && outReady[k];
         res       = stateOut[k];
         tick();
         cyc++;
         if (acceptNow && idx < 3) begin
            acceptCyc[idx] = cyc;
            idx++;
            if (idx < 3) stateIn[k] = d[idx];
            else inValid[k] = 1'b0;
         end
         if (outNow) begin
            results[got] = res;
            got++;
         end
      end
      inValid[k] = 1'b0;
      checkInt({tag, " b2b count"}, got, 3);
      if (got == 3) begin
         for (int i = 0; i < 3; i++)
            checkOutput($sformatf("%s b2b result %0d", tag, i), results[i], invModel(d[i]));
         checkInt({tag, " b2b spacing 0"}, acceptCyc[1] - acceptCyc[0], n + 2);
         checkInt({tag, " b2b spacing 1"}, acceptCyc[2] - acceptCyc[1], n + 2);
      end

      // Round trip through the forward reference
      for (int i = 0; i < 1000; i++) begin
         held = rand128();
         applyStimulus(k, fwdModel(held), cyc, res, to);
         checkBit($sformatf("%s rt %0d timeout", tag, i), to, 1'b0);
         checkOutput($sformatf("%s rt %0d", tag, i), res, held);
      end
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: time limit reached, checks so far %0d", checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{din: 128'h046681E5_E0CB199A_48F8D37A_2806264C, dout: 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5};
      vecs[1] = '{din: 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6, dout: 128'hDB135345_F20A225C_01010101_C6C6C6C6};
      vecs[2] = '{din: 128'h0, dout: 128'h0};
      vecs[3] = '{din: {4{32'hFFFFFFFF}}, dout: {4{32'hFFFFFFFF}}};
      vecs[4] = '{din: 128'h01010101_01010101_C6C6C6C6_8E4DA1BC, dout: 128'h01010101_01010101_C6C6C6C6_DB135345};

      // Reset with in_valid and out_ready high must still land in IDLE
      rstN = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         inValid[k]  = 1'b1;
         outReady[k] = 1'b1;
         stateIn[k]  = vecs[0].din;
      end
      tick();
      tick();
      for (int k = 0; k < NDUT; k++) inValid[k] = 1'b0;
      rstN = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         checkBit($sformatf("dut%0d reset in_ready", k), inReady[k], 1'b1);
         checkBit($sformatf("dut%0d reset out_valid", k), outValid[k], 1'b0);
         checkBit($sformatf("dut%0d reset busy", k), busy[k], 1'b0);
         checkOutput($sformatf("dut%0d reset state_out", k), stateOut[k], '0);
      end

      for (int k = 0; k < NDUT; k++) runDut(k);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: number of columns transformed per CALC cycle; legal values 1, 2, 4; any other value is a elaboration error.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: input state presented.
REQ-005 SHALL have port in_ready, output, 1: block can accept a state.
REQ-006 SHALL have port state_in, input, 128: AES state, column-major; column c at bits [127-32c -: 32]; byte r of column c at bits [127-32c-8r -: 8].
REQ-007 SHALL have port out_valid, output, 1: result available.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-009 SHALL have port state_out, output, 128: InvMixColumns result, same byte layout as state_in.
REQ-010 SHALL have port busy, output, 1: high in CALC and DONE.

Function
REQ-011 SHALL compute per column (a0..a3): b0=0E·a0^0B·a1^0D·a2^09·a3; b1=09·a0^0E·a1^0B·a2^0D·a3; b2=0D·a0^09·a1^0E·a2^0B·a3; b3=0B·a0^0D·a1^09·a2^0E·a3.
REQ-012 SHALL use GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (0x11B); xtime = (a<<1) ^ (a[7] ? 0x1B : 0x00), truncated to 8 bits.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1, busy=0, out_valid=0; on in_valid&&in_ready, latch state_in into a 128-bit working register, clear column counter, go to CALC.
REQ-015 CALC: each cycle transform COLS_PER_CYCLE columns starting at column index = counter, write results in place, counter += COLS_PER_CYCLE.
REQ-016 CALC SHALL last exactly 4/COLS_PER_CYCLE cycles; when the last group is written, go to DONE on the same edge.
REQ-017 Column counter SHALL be 2 bits and wrap to 0 after the last group; wrap value is don't-care outside CALC but must not cause extra writes.
REQ-018 DONE: out_valid=1, state_out = working register; on out_valid&&out_ready go to IDLE on that edge.
REQ-019 state_out SHALL be stable while out_valid=1 and out_ready=0 (unlimited backpressure).
REQ-020 in_ready SHALL be 0 in CALC and DONE; in_valid/state_in changes during those states SHALL be ignored.
REQ-021 Latency from accepting edge to first out_valid=1 cycle SHALL be 4/COLS_PER_CYCLE + 1 cycles; minimum period between accepts SHALL be 4/COLS_PER_CYCLE + 2 cycles with out_ready held 1.
REQ-022 state_out SHALL hold last result after DONE->IDLE until the next DONE; consumers SHALL sample it only when out_valid=1.
REQ-023 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-024 When rst_n=0 at a rising clk edge: FSM -> IDLE, counter -> 0, working register -> 0; hence state_out=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-025 Reset during CALC or DONE SHALL abort the operation; the partial result SHALL never appear with out_valid=1.
REQ-026 Reset SHALL take priority over any simultaneous in_valid or out_ready handshake.
REQ-027 No asynchronous path from rst_n to any flop or output.

Verification
REQ-028 Vector: state_in 046681E5_E0CB199A_48F8D37A_2806264C, out_ready=1 -> state_out D4BF5D30_E0B452AE_B84111F1_1E2798E5, out_valid after exactly 5 cycles (COLS_PER_CYCLE=1), 2 cycles (=4), 3 cycles (=2).
REQ-029 Columns: state_in 8E4DA1BC_9FDC589D_01010101_C6C6C6C6 -> state_out DB135345_F20A225C_01010101_C6C6C6C6; all-zero input -> all-zero output.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out unchanged, in_ready=0; new in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-031 Reset mid-CALC: assert rst_n=0 for one edge in the second CALC cycle -> next cycle out_valid=0, in_ready=1, state_out=0; subsequent vector from REQ-028 completes correctly.
REQ-032 Back-to-back: in_valid held 1 with three distinct states, out_ready=1 -> three results in order, accepts spaced by exactly 4/COLS_PER_CYCLE+2 cycles.
REQ-033 Round-trip: random 128-bit X fed through a reference forward MixColumns then this block -> output equals X for 1000 samples per legal COLS_PER_CYCLE.
